// File: rtl/jpeg_carry_chain_pipe.sv
// Segmented add/sub/compare pipeline: the carry chain is split into STAGES registered segments, giving STAGES cycles of latency.
// in_ready = !out_valid || out_ready; a stalled output freezes every stage in place, and bubbles are kept rather than collapsed.
module jpeg_carry_chain_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_lt,
    output logic             out_eq,
    output logic             err_mode
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_cmp [STAGES];
    logic             r_lt  [STAGES];
    logic             r_eq  [STAGES];
    logic             r_ovf;
    logic             r_err;

    logic             w_adv;
    logic             w_sub;
    logic             w_vld_n [STAGES];
    logic [WIDTH-1:0] w_a_n   [STAGES];
    logic [WIDTH-1:0] w_b_n   [STAGES];
    logic [WIDTH-1:0] w_sum_n [STAGES];
    logic             w_cin   [STAGES];
    logic             w_c_n   [STAGES];
    logic             w_cmp_n [STAGES];
    logic             w_lt_n  [STAGES];
    logic             w_eq_n  [STAGES];
    logic [SEG:0]     w_seg   [STAGES];
    logic             w_ovf_n;

    assign w_adv = !r_vld[LAST] || out_ready;
    // Subtract and compare share the a + ~b + 1 chain; in_cin only matters for add/reserved.
    assign w_sub = (in_mode == 2'b01) || (in_mode == 2'b10);

    always_comb begin
        w_vld_n[0] = in_valid;
        w_a_n[0]   = in_a;
        w_b_n[0]   = w_sub ? ~in_b : in_b;
        w_sum_n[0] = '0;
        w_cin[0]   = w_sub ? 1'b1 : in_cin;
        w_cmp_n[0] = (in_mode == 2'b10);
        w_lt_n[0]  = (in_a < in_b);
        w_eq_n[0]  = (in_a == in_b);
        for (int k = 1; k < STAGES; k++) begin
            w_vld_n[k] = r_vld[k-1];
            w_a_n[k]   = r_a[k-1];
            w_b_n[k]   = r_b[k-1];
            w_sum_n[k] = r_sum[k-1];
            w_cin[k]   = r_c[k-1];
            w_cmp_n[k] = r_cmp[k-1];
            w_lt_n[k]  = r_lt[k-1];
            w_eq_n[k]  = r_eq[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, w_a_n[k][k*SEG +: SEG]} + {1'b0, w_b_n[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_cin[k]};
            w_sum_n[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
            w_c_n[k] = w_seg[k][SEG];
        end
        // a^b^sum at the MSB recovers the carry into the MSB.
        w_ovf_n = !w_cmp_n[LAST] & (w_a_n[LAST][WIDTH-1] ^ w_b_n[LAST][WIDTH-1]
                                    ^ w_sum_n[LAST][WIDTH-1] ^ w_c_n[LAST]);
        if (w_cmp_n[LAST]) begin
            w_sum_n[LAST] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_cmp[k] <= 1'b0;
                r_lt[k]  <= 1'b0;
                r_eq[k]  <= 1'b0;
            end
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_adv) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_vld[k] <= w_vld_n[k];
                    r_a[k]   <= w_a_n[k];
                    r_b[k]   <= w_b_n[k];
                    r_sum[k] <= w_sum_n[k];
                    r_c[k]   <= w_c_n[k];
                    r_cmp[k] <= w_cmp_n[k];
                    r_lt[k]  <= w_lt_n[k];
                    r_eq[k]  <= w_eq_n[k];
                end
                r_ovf <= w_ovf_n;
            end
            if (in_valid && w_adv && (in_mode == 2'b11)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld[LAST];
    assign out_sum   = r_sum[LAST];
    assign out_cout  = r_c[LAST];
    assign out_ovf   = r_ovf;
    assign out_lt    = r_lt[LAST];
    assign out_eq    = r_eq[LAST];
    assign err_mode  = r_err;

endmodule

// File: tb/tb_jpeg_carry_chain_pipe.sv
// Bench for jpeg_carry_chain_pipe (16 bits, 2 stages): directed table, stall/reset sequences, random traffic vs a reference model.
module tb_jpeg_carry_chain_pipe;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        lt;
        logic        eq;
    } res_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        lt;
        logic        eq;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_lt;
    logic        out_eq;
    logic        err_mode;

    int   n_chk;
    int   n_fail;
    int   n_deliv;
    res_t sb_q[$];
    vec_t tbl[9];

    jpeg_carry_chain_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_lt   (out_lt),
        .out_eq   (out_eq),
        .err_mode (err_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    function automatic res_t model(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                                   input logic c);
        int   ua, ub, sa, sb, s, r;
        res_t x;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        x.lt = (ua < ub);
        x.eq = (ua == ub);
        if (m == 2'b01 || m == 2'b10) begin
            s      = ua - ub;
            r      = sa - sb;
            x.sum  = (m == 2'b10) ? 16'h0000 : s[15:0];
            x.cout = (ua >= ub);
            x.ovf  = (m == 2'b01) && (r > 32767 || r < -32768);
        end else begin
            s      = ua + ub + int'(c);
            r      = sa + sb + int'(c);
            x.sum  = s[15:0];
            x.cout = (s > 65535);
            x.ovf  = (r > 32767 || r < -32768);
        end
        return x;
    endfunction

    function automatic vec_t mkvec(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                                   input logic c);
        vec_t v;
        res_t x;
        x = model(m, a, b, c);
        v = '{m, a, b, c, x.sum, x.cout, x.ovf, x.lt, x.eq};
        return v;
    endfunction

    function automatic logic [15:0] pick();
        logic [15:0] v;
        case ($urandom_range(0, 5))
            0:       v = 16'h0000;
            1:       v = 16'hFFFF;
            2:       v = 16'h8000;
            3:       v = 16'h7FFF;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_result", 32'd1, 32'd0);
                end else begin
                    chk("sb_result", {out_sum, out_cout, out_ovf, out_lt, out_eq}, sb_q.pop_front());
                    n_deliv++;
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_mode, in_a, in_b, in_cin));
            end
        end
    end

    task automatic send_chk(input vec_t v, input string nm);
        int w;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_mode   = v.mode;
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        out_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_accept"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_early"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_sum"}, out_sum, v.sum);
        chk({nm, "_cout"}, out_cout, v.cout);
        chk({nm, "_ovf"}, out_ovf, v.ovf);
        chk({nm, "_lt"}, out_lt, v.lt);
        chk({nm, "_eq"}, out_eq, v.eq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n0, k, cyc;
        logic acc, held_vld;
        logic [18:0] held;

        n_chk = 0; n_fail = 0; n_deliv = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_mode = 2'b00;
        out_ready = 1'b1;

        tbl[0] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{2'b01, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{2'b10, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{2'b00, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{2'b00, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{2'b10, 16'h8000, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{2'b01, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_flags", {out_cout, out_ovf, out_lt, out_eq}, 0);
        chk("rst_err_mode", err_mode, 0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            send_chk(tbl[i], $sformatf("tbl%0d", i));
        end
        chk("err_mode_clear", err_mode, 0);

        send_chk('{2'b11, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0}, "rsv");
        chk("err_mode_set", err_mode, 1);
        for (int i = 0; i < 10; i++) begin
            send_chk(mkvec(2'b00, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1))), "rsv_add");
        end
        chk("err_mode_sticky", err_mode, 1);

        // Backpressure: five adds, downstream stalls on cycles 2..6.
        n0 = n_deliv; k = 0; cyc = 0; held_vld = 1'b0; held = '0;
        @(posedge clk);
        #1;
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'b00; in_cin = 1'b0;
        in_a = 16'h0100; in_b = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                chk("bp_in_ready", in_ready, 0);
                if (held_vld) chk("bp_hold", {out_sum, out_cout, out_lt, out_eq}, held);
                held = {out_sum, out_cout, out_lt, out_eq};
                held_vld = 1'b1;
            end else begin
                held_vld = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            cyc++;
            out_ready = !(cyc >= 2 && cyc <= 6);
            in_valid = (k < 5);
            in_a = 16'h0100 + 16'(k);
            in_b = 16'(k);
            if (k == 5 && n_deliv - n0 == 5) break;
        end
        chk("bp_delivered", n_deliv - n0, 5);

        // Random traffic with random stalls, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_mode   = 2'($urandom_range(0, 3));
            in_a      = pick();
            in_b      = ($urandom_range(0, 7) == 0) ? in_a : pick();
            in_cin    = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("rand_drained", sb_q.size(), 0);

        // Mid-flight reset: two results in the pipe, asynchronous pulse between edges.
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_a = 16'h1111; in_b = 16'h2222;
        @(posedge clk);
        #1 in_a = 16'h3333;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_err", err_mode, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_err_mode", err_mode, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_sum", out_sum, 0);
        sb_q.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_ghost", out_valid, 0);
        end
        send_chk(tbl[0], "post_rst");

        @(negedge clk);
        chk("final_queue_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_carry_chain_pipe.md
JPEG_CARRY_CHAIN_PIPE -- requirements
Module: jpeg_carry_chain_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 2: number of carry-chain pipeline segments; SHALL be >= 1 and SHALL divide WIDTH evenly.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input operands present.
REQ-006 in_ready  output  1  block accepts the input this cycle.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in; used in add mode only.
REQ-010 in_mode  input  2  operation: 00 add, 01 subtract, 10 compare, 11 reserved.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_sum  output  WIDTH  arithmetic result.
REQ-014 out_cout  output  1  carry-out of the MSB.
REQ-015 out_ovf  output  1  signed two's-complement overflow.
REQ-016 out_lt  output  1  unsigned in_a < in_b.
REQ-017 out_eq  output  1  in_a == in_b.
REQ-018 err_mode  output  1  sticky flag: a reserved mode was accepted.

Function
REQ-019 Transfer in: an input is accepted when in_valid && in_ready; transfer out happens when out_valid && out_ready.
REQ-020 Advance condition: adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally. Every stage register loads only when adv = 1.
REQ-021 Stage k (0..STAGES-1) SHALL resolve bits [k*W/S .. (k+1)*W/S-1] using the carry registered from stage k-1. Stage 0 uses the effective carry-in. Unresolved upper operand bits and all flags SHALL travel with the data.
REQ-022 Each stage SHALL carry a valid bit. A bubble (in_valid = 0 with adv = 1) SHALL propagate as a valid-0 slot. Bubbles are not collapsed during a stall.
REQ-023 Latency: the result of an input accepted at cycle t SHALL appear on the outputs with out_valid = 1 at cycle t+STAGES, provided adv stays 1 throughout.
REQ-024 Add (00): {out_cout, out_sum} = in_a + in_b + in_cin.
REQ-025 Subtract (01): out_sum = in_a + ~in_b + 1, truncated to WIDTH bits; in_cin is ignored; out_cout = 1 iff in_a >= in_b (unsigned).
REQ-026 Compare (10): the subtract carry chain is computed; out_sum SHALL be forced to 0; out_cout is as in subtract.
REQ-027 Reserved (11): behaves as add; err_mode SHALL set to 1 on acceptance and stay 1 until reset.
REQ-028 out_ovf = carry into MSB XOR carry out of MSB, for add and subtract. In compare mode out_ovf SHALL be 0.
REQ-029 out_lt and out_eq SHALL be valid in every mode and SHALL be computed from the accepted operands.
REQ-030 While out_valid && !out_ready, all outputs SHALL hold stable and no stage SHALL change.
REQ-031 Ordering: results SHALL leave in acceptance order; nothing is dropped or duplicated.
REQ-032 Simultaneous output and input transfer in the same cycle SHALL be supported at full throughput (one result per cycle).
REQ-033 Outputs other than out_valid are don't-care while out_valid = 0, but SHALL NOT be X after reset.

Reset
REQ-034 rst_n low SHALL immediately clear all stage valid bits, out_valid, and err_mode to 0.
REQ-035 While rst_n is low, out_sum, out_cout, out_ovf, out_lt and out_eq SHALL be 0, and in_ready SHALL be 1 (because out_valid = 0).
REQ-036 Reset asserted mid-operation SHALL discard all in-flight results. The first input accepted after rst_n deasserts SHALL be the first result out.

Verification (WIDTH=16, STAGES=2)
REQ-037 Add: A=0xFFFF, B=0x0001, cin=0, mode 00 -> 2 cycles later out_sum=0x0000, cout=1, ovf=0, lt=0, eq=0.
REQ-038 Subtract: A=0x8000, B=0x0001, mode 01 -> out_sum=0x7FFF, cout=1, ovf=1, lt=0; and A=0x0001, B=0x0002 -> out_sum=0xFFFF, cout=0, lt=1.
REQ-039 Compare: A=B=0x1234, mode 10 -> out_sum=0x0000, cout=1, ovf=0, eq=1, lt=0.
REQ-040 Backpressure: stream 5 adds (k + 0x0100, k=0..4) with out_ready=0 from cycle 2 to cycle 6 -> in_ready=0 during the stall, outputs held stable, all 5 results delivered in order with no loss.
REQ-041 Reset mid-flight: 2 inputs in the pipeline, pulse rst_n low for 1 cycle, asynchronously with no clock edge -> out_valid=0 at once, err_mode=0, neither result ever appears.
REQ-042 Reserved mode: A=0x0003, B=0x0004, mode 11 -> out_sum=0x0007, err_mode=1 and still 1 after 10 further add transactions.
